// File: rtl/xge_rx_pkg.sv
// Shared types for the MAC RX packet reader: stream word, FSM state, byte accounting.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package xge_rx_pkg;

  localparam int BYTES_PER_WORD = 8;

  typedef struct packed {
    logic [63:0] data;
    logic        sop;
    logic        eop;
    logic [2:0]  mod;
    logic        err;
  } pkt_word_t;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    READ = 1'b1
  } rx_state_e;

  // Valid bytes carried by a word; a mod of 0 means a full word.
  function automatic logic [3:0] mod_to_bytes(input logic [2:0] mod);
    return (mod == 3'd0) ? 4'(BYTES_PER_WORD) : {1'b0, mod};
  endfunction

endpackage

// File: rtl/xge_skid_buf2.sv
// Two-entry FIFO-ordered skid buffer of pkt_word_t with registered head output.
// Latency: 1 cycle from push to head_o when empty; push and pop may share a cycle.
// Backpressure: caller must never push while full (occ_o == 2 without a pop).
// Ports: push_i/push_dat_i write side, pop_i read side, head_o/vld_o head word, occ_o fill level.
module xge_skid_buf2
  import xge_rx_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       push_i,
  input  pkt_word_t  push_dat_i,
  input  logic       pop_i,
  output pkt_word_t  head_o,
  output logic       vld_o,
  output logic [1:0] occ_o
);

  pkt_word_t  head_q, head_d;
  pkt_word_t  tail_q, tail_d;
  logic [1:0] occ_q, occ_d;
  logic       pop_eff;

  // A pop against an empty buffer is ignored.
  assign pop_eff = pop_i && (occ_q != 2'd0);

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    occ_d  = occ_q;
    unique case ({push_i, pop_eff})
      2'b10: begin
        if (occ_q == 2'd0) head_d = push_dat_i;
        else               tail_d = push_dat_i;
        occ_d = occ_q + 2'd1;
      end
      2'b01: begin
        head_d = tail_q;
        occ_d  = occ_q - 2'd1;
      end
      2'b11: begin
        // Occupancy is unchanged; the new word lands behind whatever remains.
        if (occ_q == 2'd1) begin
          head_d = push_dat_i;
        end else begin
          head_d = tail_q;
          tail_d = push_dat_i;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= 2'd0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
    end
  end

  assign head_o = head_q;
  assign vld_o  = (occ_q != 2'd0);
  assign occ_o  = occ_q;

`ifndef SYNTHESIS
  a_no_push_when_full: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(push_i && (occ_q == 2'd2) && !pop_eff));
`endif

endmodule

// File: rtl/xge_pkt_rx_reader.sv
// Reads packets out of the MAC RX FIFO into a valid/ready stream; emits per-packet status and counters.
// Latency: first out_valid 2 cycles after pkt_rx_ren rises; status 1 cycle after the eop word.
// Backpressure: out_ready throttles pkt_rx_ren through the 2-entry skid buffer; status has none.
// Ports: pkt_rx_* MAC read side, out_* stream, stat_* per-packet record, clr_cnt/*_cnt statistics.
module xge_pkt_rx_reader
  import xge_rx_pkg::*;
#(
  parameter int MAX_LEN = 1518,
  parameter int LEN_W   = 16,
  parameter int CNT_W   = 32
) (
  input  logic             clk_156m25,
  input  logic             reset_156m25_n,
  input  logic             pkt_rx_avail,
  output logic             pkt_rx_ren,
  input  logic [63:0]      pkt_rx_data,
  input  logic             pkt_rx_val,
  input  logic             pkt_rx_sop,
  input  logic             pkt_rx_eop,
  input  logic [2:0]       pkt_rx_mod,
  input  logic             pkt_rx_err,
  output logic [63:0]      out_data,
  output logic             out_sop,
  output logic             out_eop,
  output logic [2:0]       out_mod,
  output logic             out_err,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             stat_valid,
  output logic [LEN_W-1:0] stat_len,
  output logic             stat_err,
  output logic             stat_oversize,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] pkt_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] proto_err_cnt
);

  localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  rx_state_e        state_q, state_d;
  logic             in_frame_q, in_frame_d;
  logic [LEN_W-1:0] len_q, len_d, len_new, len_base;
  logic [LEN_W:0]   len_sum;
  logic             stat_vld_q, stat_vld_d, stat_err_q, stat_err_d, stat_over_q, stat_over_d;
  logic [LEN_W-1:0] stat_len_q, stat_len_d;
  logic             pend_vld_q, pend_vld_d, pend_err_q, pend_err_d;
  logic [LEN_W-1:0] pend_len_q, pend_len_d;
  logic [CNT_W-1:0] pkt_cnt_q, err_cnt_q, proto_cnt_q;
  logic             orphan, trunc, fwd, close_pkt, pop;
  logic [1:0]       occ;
  logic [2:0]       occ_next;
  pkt_word_t        in_word, head;

  // ---------------- read side ----------------
  assign pop      = out_valid && out_ready;
  // Occupancy once this cycle's in-flight word and pop have settled.
  assign occ_next = {1'b0, occ} + {2'b0, pkt_rx_val} - {2'b0, pop};
  // Never read past the eop word: the next packet starts only after a pass through IDLE.
  assign pkt_rx_ren = (state_q == READ) && !(pkt_rx_val && pkt_rx_eop) && (occ_next < 3'd2);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (pkt_rx_avail) state_d = READ;
      READ:    if (pkt_rx_val && pkt_rx_eop) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------- framing and length ----------------
  assign orphan    = pkt_rx_val && !in_frame_q && !pkt_rx_sop;
  assign trunc     = pkt_rx_val &&  in_frame_q &&  pkt_rx_sop;
  assign fwd       = pkt_rx_val && (in_frame_q || pkt_rx_sop);
  assign close_pkt = fwd && pkt_rx_eop;

  assign len_base = pkt_rx_sop ? '0 : len_q;
  assign len_sum  = {1'b0, len_base} + (LEN_W+1)'(mod_to_bytes(pkt_rx_eop ? pkt_rx_mod : 3'd0));
  assign len_new  = len_sum[LEN_W] ? '1 : len_sum[LEN_W-1:0];

  assign len_d      = fwd ? len_new : len_q;
  assign in_frame_d = fwd ? !pkt_rx_eop : in_frame_q;

  assign in_word = '{data: pkt_rx_data, sop: pkt_rx_sop, eop: pkt_rx_eop,
                     mod: pkt_rx_mod, err: pkt_rx_err};

  xge_skid_buf2 u_skid (
    .clk_i      (clk_156m25),
    .rst_ni     (reset_156m25_n),
    .push_i     (fwd),
    .push_dat_i (in_word),
    .pop_i      (pop),
    .head_o     (head),
    .vld_o      (out_valid),
    .occ_o      (occ)
  );

  // ---------------- status record ----------------
  // A sop+eop word arriving mid-frame closes two packets at once; the truncated one
  // goes out first and the single-word one is parked for the following cycle, which
  // is always word-free because ren is masked on the eop word.
  always_comb begin
    stat_vld_d = 1'b0;
    stat_len_d = stat_len_q;
    stat_err_d = stat_err_q;
    pend_vld_d = 1'b0;
    pend_len_d = pend_len_q;
    pend_err_d = pend_err_q;
    if (trunc) begin
      stat_vld_d = 1'b1;
      stat_len_d = len_q;
      stat_err_d = 1'b1;
      if (close_pkt) begin
        pend_vld_d = 1'b1;
        pend_len_d = len_new;
        pend_err_d = pkt_rx_err;
      end
    end else if (close_pkt) begin
      stat_vld_d = 1'b1;
      stat_len_d = len_new;
      stat_err_d = pkt_rx_err;
    end else if (pend_vld_q) begin
      stat_vld_d = 1'b1;
      stat_len_d = pend_len_q;
      stat_err_d = pend_err_q;
    end
    stat_over_d = (stat_len_d > MAX_LEN_L);
  end

  always_ff @(posedge clk_156m25 or negedge reset_156m25_n) begin
    if (!reset_156m25_n) begin
      state_q     <= IDLE;
      in_frame_q  <= 1'b0;
      len_q       <= '0;
      stat_vld_q  <= 1'b0;
      stat_len_q  <= '0;
      stat_err_q  <= 1'b0;
      stat_over_q <= 1'b0;
      pend_vld_q  <= 1'b0;
      pend_len_q  <= '0;
      pend_err_q  <= 1'b0;
      pkt_cnt_q   <= '0;
      err_cnt_q   <= '0;
      proto_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      in_frame_q  <= in_frame_d;
      len_q       <= len_d;
      stat_vld_q  <= stat_vld_d;
      stat_len_q  <= stat_len_d;
      stat_err_q  <= stat_err_d;
      stat_over_q <= stat_over_d;
      pend_vld_q  <= pend_vld_d;
      pend_len_q  <= pend_len_d;
      pend_err_q  <= pend_err_d;
      // Counters move on the same edge that loads the status record.
      if (clr_cnt) begin
        pkt_cnt_q   <= '0;
        err_cnt_q   <= '0;
        proto_cnt_q <= '0;
      end else begin
        if (stat_vld_d)               pkt_cnt_q   <= sat_inc(pkt_cnt_q);
        if (stat_vld_d && stat_err_d) err_cnt_q   <= sat_inc(err_cnt_q);
        if (orphan || trunc)          proto_cnt_q <= sat_inc(proto_cnt_q);
      end
    end
  end

  assign out_data      = head.data;
  assign out_sop       = head.sop;
  assign out_eop       = head.eop;
  assign out_mod       = head.mod;
  assign out_err       = head.err;
  assign stat_valid    = stat_vld_q;
  assign stat_len      = stat_len_q;
  assign stat_err      = stat_err_q;
  assign stat_oversize = stat_over_q;
  assign pkt_cnt       = pkt_cnt_q;
  assign err_cnt       = err_cnt_q;
  assign proto_err_cnt = proto_cnt_q;

endmodule
